// File: rtl/digital_clock.sv
// digital_clock: 12-hour time-of-day clock with AM/PM, time-set load,
// combinational alarm compare and an independent 0..15 h stopwatch.
// One rising edge of Clk_1sec is one second.
module digital_clock (
  output logic [5:0] seconds_out,
  output logic [5:0] minutes_out,
  output logic [3:0] hours_out,
  output logic       am_pm_out,
  output logic [3:0] stopwatch_hours_out,
  output logic [5:0] stopwatch_minutes_out,
  output logic [5:0] stopwatch_seconds_out,
  output logic       alarm_ring_out,
  input  logic       Clk_1sec,
  input  logic       reset_in,
  input  logic       set_time_in,
  input  logic [3:0] set_hour_in,
  input  logic [5:0] set_minute_in,
  input  logic       set_ampm_in,
  input  logic [3:0] alarm_hour_in,
  input  logic [5:0] alarm_minute_in,
  input  logic       alarm_ampm_in,
  input  logic       stopwatch_on_in,
  input  logic       stopwatch_reset_in
);

  logic [5:0] r_sec;
  logic [5:0] r_min;
  logic [3:0] r_hour;
  logic       r_ampm;
  logic [5:0] r_sw_sec;
  logic [5:0] r_sw_min;
  logic [3:0] r_sw_hour;

  logic [5:0] w_sec_next;
  logic [5:0] w_min_next;
  logic [3:0] w_hour_next;
  logic       w_ampm_next;
  logic [3:0] w_load_hour;
  logic [5:0] w_load_min;
  logic [5:0] w_sw_sec_next;
  logic [5:0] w_sw_min_next;
  logic [3:0] w_sw_hour_next;
  logic       w_alarm_hour_valid;

  // 12-hour sequence: 12 -> 1, 1..10 -> +1, 11 -> 12; anything else recovers to 12.
  function automatic logic [3:0] next_hour(input logic [3:0] h);
    logic [3:0] n;
    case (h)
      4'd12:   n = 4'd1;
      4'd11:   n = 4'd12;
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
      4'd6, 4'd7, 4'd8, 4'd9, 4'd10:
               n = h + 4'd1;
      default: n = 4'd12;
    endcase
    return n;
  endfunction

  // Clamp the load fields: out-of-range hour loads 12, out-of-range minute loads 0.
  always_comb begin
    w_load_hour = set_hour_in;
    w_load_min  = set_minute_in;
    if ((set_hour_in == 4'd0) || (set_hour_in > 4'd12)) begin
      w_load_hour = 4'd12;
    end else begin
      w_load_hour = set_hour_in;
    end
    if (set_minute_in > 6'd59) begin
      w_load_min = 6'd0;
    end else begin
      w_load_min = set_minute_in;
    end
  end

  // Time-of-day increment; AM/PM flips only when 11:59:59 rolls to 12:00:00.
  always_comb begin
    w_sec_next  = r_sec + 6'd1;
    w_min_next  = r_min;
    w_hour_next = r_hour;
    w_ampm_next = r_ampm;
    if (r_sec >= 6'd59) begin
      w_sec_next = 6'd0;
      if (r_min >= 6'd59) begin
        w_min_next  = 6'd0;
        w_hour_next = next_hour(r_hour);
        if (r_hour == 4'd11) begin
          w_ampm_next = ~r_ampm;
        end else begin
          w_ampm_next = r_ampm;
        end
      end else begin
        w_min_next = r_min + 6'd1;
      end
    end else begin
      w_sec_next = r_sec + 6'd1;
    end
  end

  // Stopwatch increment with 15:59:59 -> 0:00:00 wrap.
  always_comb begin
    w_sw_sec_next  = r_sw_sec + 6'd1;
    w_sw_min_next  = r_sw_min;
    w_sw_hour_next = r_sw_hour;
    if (r_sw_sec >= 6'd59) begin
      w_sw_sec_next = 6'd0;
      if (r_sw_min >= 6'd59) begin
        w_sw_min_next = 6'd0;
        if (r_sw_hour == 4'd15) begin
          w_sw_hour_next = 4'd0;
        end else begin
          w_sw_hour_next = r_sw_hour + 4'd1;
        end
      end else begin
        w_sw_min_next = r_sw_min + 6'd1;
      end
    end else begin
      w_sw_sec_next = r_sw_sec + 6'd1;
    end
  end

  // Time registers: reset > load > increment.
  always_ff @(posedge Clk_1sec) begin
    if (reset_in) begin
      r_sec  <= 6'd0;
      r_min  <= 6'd0;
      r_hour <= 4'd12;
      r_ampm <= 1'b0;
    end else if (set_time_in) begin
      r_sec  <= 6'd0;
      r_min  <= w_load_min;
      r_hour <= w_load_hour;
      r_ampm <= set_ampm_in;
    end else begin
      r_sec  <= w_sec_next;
      r_min  <= w_min_next;
      r_hour <= w_hour_next;
      r_ampm <= w_ampm_next;
    end
  end

  // Stopwatch registers: reset > stopwatch clear > count > hold.
  always_ff @(posedge Clk_1sec) begin
    if (reset_in || stopwatch_reset_in) begin
      r_sw_sec  <= 6'd0;
      r_sw_min  <= 6'd0;
      r_sw_hour <= 4'd0;
    end else if (stopwatch_on_in) begin
      r_sw_sec  <= w_sw_sec_next;
      r_sw_min  <= w_sw_min_next;
      r_sw_hour <= w_sw_hour_next;
    end else begin
      r_sw_sec  <= r_sw_sec;
      r_sw_min  <= r_sw_min;
      r_sw_hour <= r_sw_hour;
    end
  end

  // Alarm matches the whole minute; an alarm hour outside 1..12 never matches.
  always_comb begin
    w_alarm_hour_valid = (alarm_hour_in >= 4'd1) && (alarm_hour_in <= 4'd12);
    alarm_ring_out     = w_alarm_hour_valid &&
                         (r_hour == alarm_hour_in) &&
                         (r_min == alarm_minute_in) &&
                         (r_ampm == alarm_ampm_in);
  end

  assign seconds_out           = r_sec;
  assign minutes_out           = r_min;
  assign hours_out             = r_hour;
  assign am_pm_out             = r_ampm;
  assign stopwatch_hours_out   = r_sw_hour;
  assign stopwatch_minutes_out = r_sw_min;
  assign stopwatch_seconds_out = r_sw_sec;

endmodule

// File: tb/tb_digital_clock.sv
// Directed bench for digital_clock: table of load/run vectors plus
// hand-written reset, alarm, stopwatch and priority sequences.
module tb_digital_clock;

  logic       clk;
  logic       reset_in;
  logic       set_time_in;
  logic [3:0] set_hour_in;
  logic [5:0] set_minute_in;
  logic       set_ampm_in;
  logic [3:0] alarm_hour_in;
  logic [5:0] alarm_minute_in;
  logic       alarm_ampm_in;
  logic       stopwatch_on_in;
  logic       stopwatch_reset_in;
  logic [5:0] seconds_out;
  logic [5:0] minutes_out;
  logic [3:0] hours_out;
  logic       am_pm_out;
  logic [3:0] sw_h;
  logic [5:0] sw_m;
  logic [5:0] sw_s;
  logic       alarm_ring_out;

  int total = 0;
  int bad   = 0;

  digital_clock dut (
    .seconds_out           (seconds_out),
    .minutes_out           (minutes_out),
    .hours_out             (hours_out),
    .am_pm_out             (am_pm_out),
    .stopwatch_hours_out   (sw_h),
    .stopwatch_minutes_out (sw_m),
    .stopwatch_seconds_out (sw_s),
    .alarm_ring_out        (alarm_ring_out),
    .Clk_1sec              (clk),
    .reset_in              (reset_in),
    .set_time_in           (set_time_in),
    .set_hour_in           (set_hour_in),
    .set_minute_in         (set_minute_in),
    .set_ampm_in           (set_ampm_in),
    .alarm_hour_in         (alarm_hour_in),
    .alarm_minute_in       (alarm_minute_in),
    .alarm_ampm_in         (alarm_ampm_in),
    .stopwatch_on_in       (stopwatch_on_in),
    .stopwatch_reset_in    (stopwatch_reset_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sh;
    logic [5:0] sm;
    logic       sa;
    int         edges;
    logic [3:0] eh;
    logic [5:0] em;
    logic [5:0] es;
    logic       ea;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_time(input string name, input int h, input int m, input int s, input int a);
    check({name, " hour"}, int'(hours_out), h);
    check({name, " min"},  int'(minutes_out), m);
    check({name, " sec"},  int'(seconds_out), s);
    check({name, " ampm"}, int'(am_pm_out), a);
  endtask

  task automatic check_sw(input string name, input int h, input int m, input int s);
    check({name, " sw_hour"}, int'(sw_h), h);
    check({name, " sw_min"},  int'(sw_m), m);
    check({name, " sw_sec"},  int'(sw_s), s);
  endtask

  // Advance n rising edges, then sit 1 time unit past the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] h, input logic [5:0] m, input logic a);
    set_hour_in   = h;
    set_minute_in = m;
    set_ampm_in   = a;
    set_time_in   = 1'b1;
    step(1);
    set_time_in   = 1'b0;
  endtask

  initial begin
    vecs[0] = '{4'd3,  6'd58, 1'b1, 0,   4'd3,  6'd58, 6'd0,  1'b1};
    vecs[1] = '{4'd3,  6'd58, 1'b1, 120, 4'd4,  6'd0,  6'd0,  1'b1};
    vecs[2] = '{4'd3,  6'd58, 1'b1, 200, 4'd4,  6'd1,  6'd20, 1'b1};
    vecs[3] = '{4'd11, 6'd59, 1'b0, 59,  4'd11, 6'd59, 6'd59, 1'b0};
    vecs[4] = '{4'd11, 6'd59, 1'b0, 60,  4'd12, 6'd0,  6'd0,  1'b1};
    vecs[5] = '{4'd11, 6'd59, 1'b1, 60,  4'd12, 6'd0,  6'd0,  1'b0};
    vecs[6] = '{4'd12, 6'd59, 1'b0, 60,  4'd1,  6'd0,  6'd0,  1'b0};
    vecs[7] = '{4'd13, 6'd60, 1'b0, 0,   4'd12, 6'd0,  6'd0,  1'b0};
    vecs[8] = '{4'd0,  6'd30, 1'b1, 0,   4'd12, 6'd30, 6'd0,  1'b1};
    vecs[9] = '{4'd10, 6'd59, 1'b1, 61,  4'd11, 6'd0,  6'd1,  1'b1};

    reset_in           = 1'b1;
    set_time_in        = 1'b0;
    set_hour_in        = 4'd1;
    set_minute_in      = 6'd0;
    set_ampm_in        = 1'b0;
    alarm_hour_in      = 4'd12;
    alarm_minute_in    = 6'd0;
    alarm_ampm_in      = 1'b0;
    stopwatch_on_in    = 1'b0;
    stopwatch_reset_in = 1'b0;

    // Reset state and alarm at 12:00 AM
    step(1);
    reset_in = 1'b0;
    check_time("reset", 12, 0, 0, 0);
    check_sw("reset", 0, 0, 0);
    check("reset alarm", int'(alarm_ring_out), 1);

    // Table: load, run, compare
    alarm_hour_in = 4'd15;
    for (int i = 0; i < 10; i++) begin
      load(vecs[i].sh, vecs[i].sm, vecs[i].sa);
      step(vecs[i].edges);
      check_time($sformatf("vec%0d", i), int'(vecs[i].eh), int'(vecs[i].em),
                 int'(vecs[i].es), int'(vecs[i].ea));
      check($sformatf("vec%0d alarm_invalid", i), int'(alarm_ring_out), 0);
    end
    check_sw("table hold", 0, 0, 0);

    // Load holds while set_time_in stays high
    set_hour_in = 4'd7; set_minute_in = 6'd15; set_ampm_in = 1'b1;
    set_time_in = 1'b1;
    step(5);
    set_time_in = 1'b0;
    check_time("load hold", 7, 15, 0, 1);

    // Alarm 4:00 PM from 3:59 PM
    alarm_hour_in = 4'd4; alarm_minute_in = 6'd0; alarm_ampm_in = 1'b1;
    load(4'd3, 6'd59, 1'b1);
    check("alarm start", int'(alarm_ring_out), 0);
    for (int k = 1; k <= 120; k++) begin
      step(1);
      check($sformatf("alarm pm k%0d", k), int'(alarm_ring_out),
            ((k >= 60) && (k < 120)) ? 1 : 0);
    end
    check_time("alarm end", 4, 1, 0, 1);

    // Alarm 4:00 AM never rings on the PM pass
    alarm_ampm_in = 1'b0;
    load(4'd3, 6'd59, 1'b1);
    for (int k = 1; k <= 120; k++) begin
      step(1);
      check($sformatf("alarm am k%0d", k), int'(alarm_ring_out), 0);
    end

    // Stopwatch counting independent of time
    alarm_hour_in = 4'd0;
    reset_in = 1'b1;
    step(1);
    reset_in = 1'b0;
    stopwatch_on_in = 1'b1;
    step(3661);
    check_sw("sw 3661", 1, 1, 1);
    check_time("tod 3661", 1, 1, 1, 0);
    stopwatch_on_in = 1'b0;
    step(10);
    check_sw("sw hold", 1, 1, 1);
    check_time("tod hold", 1, 1, 11, 0);
    stopwatch_reset_in = 1'b1;
    step(1);
    stopwatch_reset_in = 1'b0;
    check_sw("sw clear", 0, 0, 0);
    check_time("tod after sw clear", 1, 1, 12, 0);

    // Stopwatch wrap 15:59:59 -> 0:00:00
    stopwatch_on_in = 1'b1;
    step(57599);
    check_sw("sw max", 15, 59, 59);
    step(1);
    check_sw("sw wrap", 0, 0, 0);

    // Time load leaves a running stopwatch alone
    load(4'd9, 6'd30, 1'b0);
    check_sw("sw during load", 0, 0, 1);
    check_time("load with sw", 9, 30, 0, 0);

    // reset_in beats set_time_in and clears the stopwatch
    step(5);
    set_hour_in = 4'd5; set_minute_in = 6'd5; set_ampm_in = 1'b1;
    set_time_in = 1'b1;
    reset_in    = 1'b1;
    step(1);
    set_time_in = 1'b0;
    reset_in    = 1'b0;
    stopwatch_on_in = 1'b0;
    check_time("reset prio", 12, 0, 0, 0);
    check_sw("reset prio", 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
